// File: rtl/cnn_mul_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the conv1 multiplier arbiter.
package cnn_mul_arb_pkg;

    // Largest requester count the arbiter supports; tag fields are sized for it.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    // Operand and product widths of the shared DSP-mapped multiplier.
    localparam int A_WIDTH = 14;
    localparam int B_WIDTH = 7;
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    // One pipeline stage record: valid, one-hot lane tag and the operands.
    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] tag;
        logic [A_WIDTH-1:0] a;
        logic [B_WIDTH-1:0] b;
    } stage_rec_t;

    // Round-robin pick over the low n bits of req, starting at ptr:
    // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int                 ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] rot;
        logic [MAX_REQ-1:0] first;
        logic [MAX_REQ-1:0] grant;
        logic [IDX_W-1:0]   idx;
        rot   = '0;
        grant = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx    = IDX_W'((ptr + k) % n);
                rot[k] = req[idx];
            end
        end
        first = rot & (~rot + MAX_REQ'(1));
        for (int k = 0; k < MAX_REQ; k++) begin
            if ((k < n) && first[k]) begin
                idx        = IDX_W'((ptr + k) % n);
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/cnn_mul_arb_pipe_mul.sv
// MUL_LAT-stage signed x unsigned multiplier. Each stage advances only when its
// enable is set, so the final stage holds the last product between results.
module cnn_mul_arb_pipe_mul #(
    parameter int A_WIDTH = 14,
    parameter int B_WIDTH = 7,
    parameter int P_WIDTH = 21,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MUL_LAT-1:0] stage_en,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] p
);

    logic [P_WIDTH-1:0]        a_ext;
    logic [P_WIDTH-1:0]        b_ext;
    logic signed [P_WIDTH-1:0] prod;
    logic [P_WIDTH-1:0]        p_q [MUL_LAT];
    logic [P_WIDTH-1:0]        p_d [MUL_LAT];

    // b is unsigned, so it is zero-extended; a is sign-extended. Full-width
    // product cannot overflow since P_WIDTH = A_WIDTH + B_WIDTH.
    assign a_ext = {{(P_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a};
    assign b_ext = {{(P_WIDTH-B_WIDTH){1'b0}}, b};
    assign prod  = $signed(a_ext) * $signed(b_ext);

    // Next-state of each product stage: load from upstream when enabled, else hold.
    always_comb begin
        p_d[0] = stage_en[0] ? P_WIDTH'(prod) : p_q[0];
        for (int s = 1; s < MUL_LAT; s++) begin
            p_d[s] = stage_en[s] ? p_q[s-1] : p_q[s];
        end
    end

    // Product stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                p_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < MUL_LAT; s++) begin
                p_q[s] <= p_d[s];
            end
        end
    end

    assign p = p_q[MUL_LAT-1];

endmodule

// File: rtl/cnn_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ conv1 lanes.
// Issue register (stage 1) holds operands and tag; the tag/valid pipeline runs
// beside the multiplier so each product returns to its issuing lane.
module cnn_mul_arbiter
    import cnn_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       ap_ce,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [P_WIDTH-1:0]         rsp_p,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] grant_full;
    logic [NUM_REQ-1:0] grant;
    logic               transfer;
    stage_rec_t         s1_q, s1_d;
    logic [MUL_LAT-1:0] valid_q, valid_d;
    logic [NUM_REQ-1:0] tag_q [MUL_LAT];
    logic [NUM_REQ-1:0] tag_d [MUL_LAT];
    logic [MUL_LAT-1:0] stage_en;
    logic [P_WIDTH-1:0] mul_p;
    logic               unused_bits;

    // Combinational grant: first valid lane at or after rr_ptr; none under reset or ce low.
    always_comb begin
        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = req_valid;
        grant_full             = rr_pick(req_pad, int'(rr_ptr_q), NUM_REQ);
        grant                  = '0;
        if (ap_ce && !ap_rst) begin
            grant = grant_full[NUM_REQ-1:0];
        end
    end

    assign req_ready = grant;
    assign transfer  = |grant;

    // Issue: capture the granted lane's operands and tag; priority moves past it.
    always_comb begin
        s1_d       = s1_q;
        s1_d.valid = transfer;
        rr_ptr_d   = rr_ptr_q;
        if (transfer) begin
            s1_d.tag              = '0;
            s1_d.tag[NUM_REQ-1:0] = grant;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                s1_d.a   = req_a[i*A_WIDTH +: A_WIDTH];
                s1_d.b   = req_b[i*B_WIDTH +: B_WIDTH];
                rr_ptr_d = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // Tag/valid pipeline beside the multiplier; tags only load with a valid op.
    always_comb begin
        valid_d[0]  = s1_q.valid;
        tag_d[0]    = s1_q.valid ? s1_q.tag[NUM_REQ-1:0] : tag_q[0];
        stage_en[0] = ap_ce & s1_q.valid;
        for (int s = 1; s < MUL_LAT; s++) begin
            valid_d[s]  = valid_q[s-1];
            tag_d[s]    = valid_q[s-1] ? tag_q[s-1] : tag_q[s];
            stage_en[s] = ap_ce & valid_q[s-1];
        end
    end

    // State registers; ap_ce low freezes everything, reset drops in-flight ops.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rr_ptr_q <= '0;
            s1_q     <= '0;
            valid_q  <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else if (ap_ce) begin
            rr_ptr_q <= rr_ptr_d;
            s1_q     <= s1_d;
            valid_q  <= valid_d;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    cnn_mul_arb_pipe_mul #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .P_WIDTH (P_WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .stage_en (stage_en),
        .a        (s1_q.a),
        .b        (s1_q.b),
        .p        (mul_p)
    );

    assign rsp_valid = valid_q[MUL_LAT-1] ? tag_q[MUL_LAT-1] : '0;
    assign rsp_p     = mul_p;
    assign busy      = s1_q.valid | (|valid_q);

    // Tag and pick vectors are sized for MAX_REQ; bits above NUM_REQ are always zero.
    assign unused_bits = ^{s1_q.tag, grant_full};

endmodule

// File: tb/tb_cnn_mul_arbiter.sv
// Directed and randomised checks for cnn_mul_arbiter (NUM_REQ=4, MUL_LAT=2).
module tb_cnn_mul_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 14;
    localparam int BW  = 7;
    localparam int PW  = 21;
    localparam int LAT = 2;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic            ap_ce;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic [NR-1:0]   rsp_valid;
    logic [PW-1:0]   rsp_p;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    cnn_mul_arbiter #(.NUM_REQ(NR), .MUL_LAT(LAT)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_ce     (ap_ce),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_lane(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    task automatic reset_dut();
        ap_rst    = 1'b1;
        ap_ce     = 1'b1;
        req_valid = '0;
        step();
        step();
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        ap_ce     = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        step();
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        n_cmp++;
        if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0000", rsp_valid); end
        n_cmp++;
        if (rsp_p !== 21'd0) begin n_bad++; $display("FAIL rst_rsp_p got %0d want 0", rsp_p); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++;
        ap_rst = 1'b0;
        #1;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_first_grant got %b want 0001", req_ready); end
        n_cmp++;
        req_valid = '0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [PW-1:0] ep;
        reset_dut();
        set_lane(0, -8192, 127);
        req_valid = 4'b0001;
        #1;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL t1_ready got %b want 0001", req_ready); end
        n_cmp++;
        step();
        req_valid = '0;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %b want 1", busy); end
        n_cmp++;
        step();
        if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL t1_early got %b want 0000", rsp_valid); end
        n_cmp++;
        step();
        ep = PW'(-1040384);
        if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL t1_rsp_valid got %b want 0001", rsp_valid); end
        n_cmp++;
        if (rsp_p !== ep) begin n_bad++; $display("FAIL t1_rsp_p got %0d want %0d", $signed(rsp_p), $signed(ep)); end
        n_cmp++;
        step();
        if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL t1_pulse got %b want 0000", rsp_valid); end
        n_cmp++;
        if (rsp_p !== ep) begin n_bad++; $display("FAIL t1_hold got %0d want %0d", $signed(rsp_p), $signed(ep)); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_idle got %b want 0", busy); end
        n_cmp++;
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        int            lp [4];
        logic [NR-1:0] ev;
        logic [PW-1:0] ep;
        lp = '{3000, -10000, 21000, -36000};
        reset_dut();
        set_lane(0, 1000, 3);
        set_lane(1, -2000, 5);
        set_lane(2, 3000, 7);
        set_lane(3, -4000, 9);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                req_valid = 4'hF;
                #1;
                ev = NR'(1 << (k % 4));
                if (req_ready !== ev) begin n_bad++; $display("FAIL t2_grant k=%0d got %b want %b", k, req_ready, ev); end
                n_cmp++;
            end else begin
                req_valid = '0;
            end
            step();
            if (k >= 2) begin
                ev = NR'(1 << ((k - 2) % 4));
                ep = PW'(lp[(k - 2) % 4]);
                if (rsp_valid !== ev) begin n_bad++; $display("FAIL t2_rsp_valid k=%0d got %b want %b", k, rsp_valid, ev); end
                n_cmp++;
                if (rsp_p !== ep) begin n_bad++; $display("FAIL t2_rsp_p k=%0d got %0d want %0d", k, $signed(rsp_p), $signed(ep)); end
                n_cmp++;
            end
        end
        step();
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL t2_drain got %b/%b want 0000/0", rsp_valid, busy); end
        n_cmp++;
        $display("test_back_to_back done");
    endtask

    task automatic test_priority_skip();
        logic [PW-1:0] ep;
        reset_dut();
        set_lane(1, -3, 4);
        req_valid = 4'b0010;
        #1;
        if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL t3_pre_grant got %b want 0010", req_ready); end
        n_cmp++;
        step();
        req_valid = '0;
        step();
        step();
        ep = PW'(-12);
        if (rsp_valid !== 4'b0010 || rsp_p !== ep) begin n_bad++; $display("FAIL t3_pre_rsp got %b/%0d want 0010/-12", rsp_valid, $signed(rsp_p)); end
        n_cmp++;
        step();
        set_lane(3, 8191, 127);
        set_lane(1, 5, 0);
        req_valid = 4'b1010;
        #1;
        if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL t3_grant_first got %b want 1000", req_ready); end
        n_cmp++;
        step();
        req_valid = 4'b0010;
        #1;
        if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL t3_grant_second got %b want 0010", req_ready); end
        n_cmp++;
        step();
        req_valid = '0;
        step();
        ep = PW'(1040257);
        if (rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL t3_rsp3_valid got %b want 1000", rsp_valid); end
        n_cmp++;
        if (rsp_p !== ep) begin n_bad++; $display("FAIL t3_rsp3_p got %0d want 1040257", $signed(rsp_p)); end
        n_cmp++;
        step();
        if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL t3_rsp1_valid got %b want 0010", rsp_valid); end
        n_cmp++;
        if (rsp_p !== 21'd0) begin n_bad++; $display("FAIL t3_rsp1_p got %0d want 0", $signed(rsp_p)); end
        n_cmp++;
        $display("test_priority_skip done");
    endtask

    task automatic test_ce_freeze();
        logic [PW-1:0] ep;
        reset_dut();
        set_lane(0, 100, 2);
        set_lane(2, -50, 3);
        set_lane(3, 7, 1);
        req_valid = 4'b0101;
        #1;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL t4_grant0 got %b want 0001", req_ready); end
        n_cmp++;
        step();
        req_valid = 4'b0100;
        #1;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL t4_grant2 got %b want 0100", req_ready); end
        n_cmp++;
        step();
        ap_ce     = 1'b0;
        req_valid = 4'b1001;
        for (int j = 0; j < 3; j++) begin
            #1;
            if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL t4_ce_ready j=%0d got %b want 0000", j, req_ready); end
            n_cmp++;
            step();
            if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin n_bad++; $display("FAIL t4_ce_hold j=%0d got %b/%b want 0000/1", j, rsp_valid, busy); end
            n_cmp++;
        end
        ap_ce = 1'b1;
        #1;
        if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL t4_ptr_frozen got %b want 1000", req_ready); end
        n_cmp++;
        step();
        req_valid = '0;
        ep = PW'(200);
        if (rsp_valid !== 4'b0001 || rsp_p !== ep) begin n_bad++; $display("FAIL t4_rsp0 got %b/%0d want 0001/200", rsp_valid, $signed(rsp_p)); end
        n_cmp++;
        step();
        ep = PW'(-150);
        if (rsp_valid !== 4'b0100 || rsp_p !== ep) begin n_bad++; $display("FAIL t4_rsp2 got %b/%0d want 0100/-150", rsp_valid, $signed(rsp_p)); end
        n_cmp++;
        step();
        ep = PW'(7);
        if (rsp_valid !== 4'b1000 || rsp_p !== ep) begin n_bad++; $display("FAIL t4_rsp3 got %b/%0d want 1000/7", rsp_valid, $signed(rsp_p)); end
        n_cmp++;
        $display("test_ce_freeze done");
    endtask

    task automatic test_reset_midflight();
        logic [PW-1:0] ep;
        reset_dut();
        set_lane(0, 11, 2);
        set_lane(1, 13, 3);
        req_valid = 4'b0011;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        ep = PW'(22);
        if (rsp_valid !== 4'b0001 || rsp_p !== ep) begin n_bad++; $display("FAIL t5_pre got %b/%0d want 0001/22", rsp_valid, $signed(rsp_p)); end
        n_cmp++;
        req_valid = 4'b0110;
        ap_rst    = 1'b1;
        #1;
        if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL t5_rsp_drop got %b want 0000", rsp_valid); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL t5_busy_drop got %b want 0", busy); end
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL t5_ready_drop got %b want 0000", req_ready); end
        n_cmp++;
        if (rsp_p !== 21'd0) begin n_bad++; $display("FAIL t5_rsp_p_clear got %0d want 0", $signed(rsp_p)); end
        n_cmp++;
        step();
        ap_rst    = 1'b0;
        req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL t5_stale j=%0d got %b want 0000", j, rsp_valid); end
            n_cmp++;
        end
        req_valid = 4'b0110;
        #1;
        if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL t5_regrant got %b want 0010", req_ready); end
        n_cmp++;
        req_valid = '0;
        $display("test_reset_midflight done");
    endtask

    task automatic test_random();
        logic [NR-1:0] pend;
        logic [NR-1:0] g;
        int            waitc [NR];
        int            mptr;
        logic [NR-1:0] mt [LAT+1];
        logic [PW-1:0] mp [LAT+1];
        logic [PW-1:0] lane_p [NR];
        logic [PW-1:0] gp;
        int            a_raw, b_raw, prod, idx, n_tx;
        logic [AW-1:0] a14;
        reset_dut();
        pend = '0;
        mptr = 0;
        n_tx = 0;
        for (int i = 0; i < NR; i++) begin
            waitc[i]  = 0;
            lane_p[i] = '0;
        end
        for (int s = 0; s <= LAT; s++) begin
            mt[s] = '0;
            mp[s] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && cyc < 2980 && $urandom_range(0, 2) == 0) begin
                    a_raw = int'($urandom_range(0, 16383));
                    b_raw = int'($urandom_range(0, 127));
                    a14   = AW'(a_raw);
                    prod  = int'($signed(a14)) * b_raw;
                    set_lane(i, a_raw, b_raw);
                    lane_p[i] = PW'(prod);
                    pend[i]   = 1'b1;
                    waitc[i]  = 0;
                end
            end
            req_valid = pend;
            #1;
            g  = '0;
            gp = '0;
            if (ap_ce) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (mptr + k) % NR;
                    if (pend[idx] && g == '0) begin
                        g[idx] = 1'b1;
                        gp     = lane_p[idx];
                    end
                end
            end
            if (req_ready !== g) begin n_bad++; $display("FAIL t6_grant cyc=%0d got %b want %b", cyc, req_ready, g); end
            n_cmp++;
            step();
            if (ap_ce) begin
                for (int s = LAT; s > 0; s--) begin
                    mt[s] = mt[s-1];
                    mp[s] = mp[s-1];
                end
                mt[0] = g;
                mp[0] = gp;
                for (int i = 0; i < NR; i++) begin
                    if (g[i]) begin
                        if (waitc[i] > NR - 1) begin n_bad++; $display("FAIL t6_starve lane=%0d got %0d want <=%0d", i, waitc[i], NR - 1); end
                        n_cmp++;
                        pend[i] = 1'b0;
                        mptr    = (i + 1) % NR;
                        n_tx++;
                    end else if (pend[i] && g != '0) begin
                        waitc[i]++;
                    end
                end
            end
            if (rsp_valid !== mt[LAT]) begin n_bad++; $display("FAIL t6_rsp_valid cyc=%0d got %b want %b", cyc, rsp_valid, mt[LAT]); end
            n_cmp++;
            if (mt[LAT] != '0) begin
                if (rsp_p !== mp[LAT]) begin n_bad++; $display("FAIL t6_rsp_p cyc=%0d got %0d want %0d", cyc, $signed(rsp_p), $signed(mp[LAT])); end
                n_cmp++;
            end
            ap_ce = ($urandom_range(0, 9) != 0);
        end
        ap_ce     = 1'b1;
        req_valid = '0;
        $display("test_random done: %0d transfers", n_tx);
    endtask

    initial begin
        ap_rst    = 1'b1;
        ap_ce     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_priority_skip();
        test_ce_freeze();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
